// File: rtl/alu_issue_queue.sv
// Issue stage for a combinational ALU: in-order request FIFO whose head drives the ALU, result registered into an output slot.
// Latency: accept to out_valid is two edges; in_ready depends on FIFO fullness only, so out_ready never reaches it combinationally.
module alu_issue_queue #(
  parameter int DATA_WIDTH  = 32,
  parameter int OP_WIDTH    = 4,
  parameter int DEPTH       = 4,
  parameter int NUM_OPS     = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_a,
  input  logic [DATA_WIDTH-1:0]  in_b,
  input  logic [OP_WIDTH-1:0]    in_op,
  output logic [DATA_WIDTH-1:0]  alu_a,
  output logic [DATA_WIDTH-1:0]  alu_b,
  output logic [OP_WIDTH-1:0]    alu_op,
  input  logic [DATA_WIDTH-1:0]  alu_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_result,
  output logic [OP_WIDTH-1:0]    out_op,
  output logic                   out_illegal,
  output logic [$clog2(DEPTH):0] level,
  output logic [COUNT_WIDTH-1:0] op_count
);
  localparam int PW   = $clog2(DEPTH);
  localparam int LW   = PW + 1;
  localparam int OPW1 = OP_WIDTH + 1;
  localparam logic [LW-1:0]   FULL_LEVEL = LW'(DEPTH);
  localparam logic [OPW1-1:0] OP_LIMIT   = OPW1'(NUM_OPS);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [OP_WIDTH-1:0]   op;
  } entry_t;

  entry_t                 mem_q [DEPTH];
  entry_t                 mem_d [DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_result_q, out_result_d;
  logic [OP_WIDTH-1:0]    out_op_q, out_op_d;
  logic                   out_illegal_q, out_illegal_d;
  logic [COUNT_WIDTH-1:0] op_count_q, op_count_d;

  logic   empty;
  logic   push;
  logic   pop;
  logic   hs;
  entry_t head;

  always_comb begin
    empty    = (level_q == '0);
    in_ready = (level_q != FULL_LEVEL);
    push     = in_valid && in_ready;
    // The slot can take a new result when it is empty or being drained this cycle.
    pop      = !empty && (!out_valid_q || out_ready);
    hs       = out_valid_q && out_ready;
    head     = mem_q[rd_ptr_q];

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{a: in_a, b: in_b, op: in_op};
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  always_comb begin
    alu_a  = empty ? '0 : head.a;
    alu_b  = empty ? '0 : head.b;
    alu_op = empty ? '0 : head.op;
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_op_d      = out_op_q;
    out_illegal_d = out_illegal_q;
    if (pop) begin
      out_valid_d   = 1'b1;
      out_result_d  = alu_result;
      out_op_d      = head.op;
      out_illegal_d = ({1'b0, head.op} >= OP_LIMIT);
    end else if (hs) begin
      out_valid_d = 1'b0;
    end
    op_count_d = op_count_q + COUNT_WIDTH'(hs);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_op_q      <= '0;
      out_illegal_q <= 1'b0;
      op_count_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_op_q      <= out_op_d;
      out_illegal_q <= out_illegal_d;
      op_count_q    <= op_count_d;
    end
  end

  // Storage needs no reset: entries are only observed while counted in level.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_op      = out_op_q;
  assign out_illegal = out_illegal_q;
  assign level       = level_q;
  assign op_count    = op_count_q;

endmodule
